// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - UART byte endpoint with TX/RX FIFOs, 16x oversampled receiver.
// Optional even parity: define UART_PARITY_EN (frame becomes 8E1 instead of 8N1).
module uart_transceiver #(
    parameter int NB_UART_DATA    = 8,
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD_RATE       = 19_200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_rx,
    output logic                    o_tx,
    input  logic                    i_wr,
    input  logic [NB_UART_DATA-1:0] i_wdata,
    input  logic                    i_tx_start,
    input  logic                    i_rd,
    output logic [NB_UART_DATA-1:0] o_rx_data,
    output logic                    o_rx_done,
    output logic                    o_tx_done,
    output logic                    o_tx_full,
    output logic                    o_rx_empty,
    output logic                    o_rx_err
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int NW    = (NB_UART_DATA > 1) ? $clog2(NB_UART_DATA) : 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Free-running 16x baud tick
    logic [CW-1:0] tick_cnt;
    logic          tick;
    assign tick = (tick_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (i_rst || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    logic rx_meta, rx_sync;
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- RX FSM ----------------
    state_t                  rx_state, rx_state_nxt;
    logic [3:0]              rx_s, rx_s_nxt;
    logic [NW-1:0]           rx_n, rx_n_nxt;
    logic [NB_UART_DATA-1:0] rx_shift, rx_shift_nxt;
    logic                    rx_push, rx_bad;
`ifdef UART_PARITY_EN
    logic                    rx_perr, rx_perr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            rx_state <= S_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_perr  <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_nxt;
            rx_s     <= rx_s_nxt;
            rx_n     <= rx_n_nxt;
            rx_shift <= rx_shift_nxt;
`ifdef UART_PARITY_EN
            rx_perr  <= rx_perr_nxt;
`endif
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_s_nxt     = rx_s;
        rx_n_nxt     = rx_n;
        rx_shift_nxt = rx_shift;
        rx_push      = 1'b0;
        rx_bad       = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_nxt  = rx_perr;
`endif
        case (rx_state)
            S_IDLE: begin
                if (!rx_sync) begin
                    rx_state_nxt = S_START;
                    rx_s_nxt     = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s == 4'd7) begin
                        rx_s_nxt     = '0;
                        rx_n_nxt     = '0;
                        rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_s_nxt = rx_s + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_nxt     = '0;
                        rx_shift_nxt = {rx_sync, rx_shift[NB_UART_DATA-1:1]};
                        if (rx_n == NW'(NB_UART_DATA - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state_nxt = S_PARITY;
`else
                            rx_state_nxt = S_STOP;
`endif
                        end else begin
                            rx_n_nxt = rx_n + 1'b1;
                        end
                    end else begin
                        rx_s_nxt = rx_s + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_nxt     = '0;
                        rx_perr_nxt  = rx_sync ^ (^rx_shift);
                        rx_state_nxt = S_STOP;
                    end else begin
                        rx_s_nxt = rx_s + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rx_s == 4'd15) begin
                        rx_s_nxt     = '0;
                        rx_state_nxt = S_IDLE;
`ifdef UART_PARITY_EN
                        rx_push = rx_sync && !rx_perr;
                        rx_bad  = !rx_sync || rx_perr;
`else
                        rx_push = rx_sync;
                        rx_bad  = !rx_sync;
`endif
                    end else begin
                        rx_s_nxt = rx_s + 1'b1;
                    end
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [NB_UART_DATA-1:0] rx_mem [DEPTH];
    logic [PW-1:0]           rx_wp, rx_rp;
    logic [PW:0]             rx_cnt;
    logic                    rx_pop, rx_full, rx_wr, rx_overrun;

    assign rx_pop     = i_rd && (rx_cnt != '0);
    assign rx_full    = (rx_cnt == (PW+1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign rx_wr      = rx_push && (!rx_full || rx_pop);
    assign rx_overrun = rx_push && !rx_wr;
    assign o_rx_empty = (rx_cnt == '0);
    assign o_rx_data  = o_rx_empty ? '0 : rx_mem[rx_rp];

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            rx_wp     <= '0;
            rx_rp     <= '0;
            rx_cnt    <= '0;
            o_rx_done <= 1'b0;
            o_rx_err  <= 1'b0;
        end else begin
            if (rx_wr)  rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            rx_cnt    <= rx_cnt + (PW+1)'(rx_wr) - (PW+1)'(rx_pop);
            o_rx_done <= rx_wr;
            o_rx_err  <= rx_bad || rx_overrun;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [NB_UART_DATA-1:0] tx_mem [DEPTH];
    logic [PW-1:0]           tx_wp, tx_rp;
    logic [PW:0]             tx_cnt;
    logic                    tx_push, tx_pop, tx_nempty;
    logic [NB_UART_DATA-1:0] tx_head;

    assign o_tx_full = (tx_cnt == (PW+1)'(DEPTH));
    assign tx_push   = i_wr && !o_tx_full;
    assign tx_nempty = (tx_cnt != '0);
    assign tx_head   = tx_mem[tx_rp];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + (PW+1)'(tx_push) - (PW+1)'(tx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    state_t                  tx_state, tx_state_nxt;
    logic [3:0]              tx_s, tx_s_nxt;
    logic [NW-1:0]           tx_n, tx_n_nxt;
    logic [NB_UART_DATA-1:0] tx_shift, tx_shift_nxt;
    logic                    tx_armed, tx_armed_nxt;
    logic                    tx_line_nxt, tx_done_nxt;
`ifdef UART_PARITY_EN
    logic                    tx_par, tx_par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            tx_state  <= S_IDLE;
            tx_s      <= '0;
            tx_n      <= '0;
            tx_shift  <= '0;
            tx_armed  <= 1'b0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_state  <= tx_state_nxt;
            tx_s      <= tx_s_nxt;
            tx_n      <= tx_n_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_armed  <= tx_armed_nxt;
            o_tx      <= tx_line_nxt;
            o_tx_done <= tx_done_nxt;
`ifdef UART_PARITY_EN
            tx_par    <= tx_par_nxt;
`endif
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_s_nxt     = tx_s;
        tx_n_nxt     = tx_n;
        tx_shift_nxt = tx_shift;
        tx_armed_nxt = tx_armed | i_tx_start;
        tx_pop       = 1'b0;
        tx_done_nxt  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        case (tx_state)
            S_IDLE: begin
                if (tx_armed && tx_nempty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = tx_head;
                    tx_s_nxt     = '0;
                    tx_state_nxt = S_START;
`ifdef UART_PARITY_EN
                    tx_par_nxt   = ^tx_head;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    if (tx_s == 4'd15) begin
                        tx_s_nxt     = '0;
                        tx_n_nxt     = '0;
                        tx_state_nxt = S_DATA;
                    end else begin
                        tx_s_nxt = tx_s + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tx_s == 4'd15) begin
                        tx_s_nxt     = '0;
                        tx_shift_nxt = tx_shift >> 1;
                        if (tx_n == NW'(NB_UART_DATA - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state_nxt = S_PARITY;
`else
                            tx_state_nxt = S_STOP;
`endif
                        end else begin
                            tx_n_nxt = tx_n + 1'b1;
                        end
                    end else begin
                        tx_s_nxt = tx_s + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (tx_s == 4'd15) begin
                        tx_s_nxt     = '0;
                        tx_state_nxt = S_STOP;
                    end else begin
                        tx_s_nxt = tx_s + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (tx_s == 4'd15) begin
                        tx_s_nxt    = '0;
                        tx_done_nxt = 1'b1;
                        // Back-to-back frames: next start bit follows the stop bit directly
                        if (tx_nempty) begin
                            tx_pop       = 1'b1;
                            tx_shift_nxt = tx_head;
                            tx_state_nxt = S_START;
`ifdef UART_PARITY_EN
                            tx_par_nxt   = ^tx_head;
`endif
                        end else begin
                            tx_state_nxt = S_IDLE;
                            tx_armed_nxt = i_tx_start;
                        end
                    end else begin
                        tx_s_nxt = tx_s + 1'b1;
                    end
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase

        case (tx_state_nxt)
            S_START:  tx_line_nxt = 1'b0;
            S_DATA:   tx_line_nxt = tx_shift_nxt[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_line_nxt = tx_par_nxt;
`endif
            default:  tx_line_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed self-checking bench for uart_transceiver.
module tb_uart_transceiver;
    localparam int BIT = 160;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx;
    logic       o_tx;
    logic       i_wr = 1'b0;
    logic [7:0] i_wdata = 8'h00;
    logic       i_tx_start = 1'b0;
    logic       i_rd = 1'b0;
    logic [7:0] o_rx_data;
    logic       o_rx_done, o_tx_done, o_tx_full, o_rx_empty, o_rx_err;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;

    assign i_rx = loop ? o_tx : rx_drv;

    uart_transceiver #(
        .NB_UART_DATA(8), .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_rx(i_rx), .o_tx(o_tx),
        .i_wr(i_wr), .i_wdata(i_wdata), .i_tx_start(i_tx_start), .i_rd(i_rd),
        .o_rx_data(o_rx_data), .o_rx_done(o_rx_done), .o_tx_done(o_tx_done),
        .o_tx_full(o_tx_full), .o_rx_empty(o_rx_empty), .o_rx_err(o_rx_err)
    );

    always #5 clk = ~clk;

    int n_rxd = 0, n_txd = 0, n_err = 0;
    always @(negedge clk) begin
        if (o_rx_done) n_rxd++;
        if (o_tx_done) n_txd++;
        if (o_rx_err)  n_err++;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Drives one frame on rx_drv; stop bit level/length are adjustable for error cases
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input int stop_len, input logic stop_val);
        for (int k = 0; k < FB - 1; k++) begin
            rx_drv = fbit(b, k) ^ ((FB == 11 && k == 9) ? par_flip : 1'b0);
            cyc(BIT);
        end
        rx_drv = stop_val;
        cyc(stop_len);
        rx_drv = 1'b1;
        cyc(BIT);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        i_wr = 1'b1; i_wdata = b; cyc(1); i_wr = 1'b0;
    endtask

    task automatic pulse_start();
        i_tx_start = 1'b1; cyc(1); i_tx_start = 1'b0;
    endtask

    task automatic pulse_rd();
        i_rd = 1'b1; cyc(1); i_rd = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; cyc(3); i_rst = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int lim = 0;
        while (o_tx !== 1'b0 && lim < 2000) begin cyc(1); lim++; end
        check(tag, o_tx, 1'b0);
    endtask

    initial begin
        int b_rx, b_tx, b_err, lim, e, tgt;
        logic [7:0] pat;

        // 1. reset and idle
        do_reset();
        check("rst_tx", o_tx, 1'b1);
        check("rst_rx_empty", o_rx_empty, 1'b1);
        check("rst_tx_full", o_tx_full, 1'b0);
        check("rst_rx_data", o_rx_data, 8'h00);
        b_rx = n_rxd; b_tx = n_txd; b_err = n_err;
        cyc(2000);
        check("idle_rx_done", n_rxd - b_rx, 0);
        check("idle_tx_done", n_txd - b_tx, 0);
        check("idle_rx_err", n_err - b_err, 0);
        check("idle_tx", o_tx, 1'b1);

        // 2. TX burst A5, 3C
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        b_tx = n_txd;
        pulse_start();
        wait_tx_low("burst_start");
        e = 0;
        for (int k = 0; k < 2 * FB; k++) begin
            tgt = 80 + BIT * k;
            cyc(tgt - e);
            e = tgt;
            pat = (k < FB) ? 8'hA5 : 8'h3C;
            check($sformatf("burst_bit%0d", k), o_tx, fbit(pat, k % FB));
            if (k == FB - 1) check("burst_done_early", n_txd - b_tx, 0);
            if (k == FB)     check("burst_done_1", n_txd - b_tx, 1);
        end
        cyc(2 * FB * BIT + 20 - e);
        check("burst_done_2", n_txd - b_tx, 2);
        wr_byte(8'h11);
        cyc(400);
        check("disarmed_tx", o_tx, 1'b1);
        check("disarmed_done", n_txd - b_tx, 2);
        do_reset();

        // 3. loopback 5A
        loop = 1'b1;
        b_rx = n_rxd; b_err = n_err;
        wr_byte(8'h5A);
        pulse_start();
        lim = 0;
        while (n_rxd - b_rx < 1 && lim < 2500) begin cyc(1); lim++; end
        check("loop_rx_seen", n_rxd - b_rx, 1);
        check("loop_data", o_rx_data, 8'h5A);
        check("loop_not_empty", o_rx_empty, 1'b0);
        cyc(200);
        check("loop_once", n_rxd - b_rx, 1);
        check("loop_no_err", n_err - b_err, 0);
        loop = 1'b0;
        pulse_rd();
        check("loop_rd_empty", o_rx_empty, 1'b1);
        check("loop_rd_data", o_rx_data, 8'h00);

        // 4. glitch, framing error, recovery
        b_rx = n_rxd; b_err = n_err;
        rx_drv = 1'b0; cyc(40); rx_drv = 1'b1;
        cyc(300);
        check("glitch_no_done", n_rxd - b_rx, 0);
        check("glitch_no_err", n_err - b_err, 0);
        send_frame(8'h81, 1'b0, 100, 1'b0);
        cyc(300);
        check("frm_err", n_err - b_err, 1);
        check("frm_no_done", n_rxd - b_rx, 0);
        check("frm_empty", o_rx_empty, 1'b1);
        send_frame(8'h7E, 1'b0, BIT, 1'b1);
        check("frm_next_done", n_rxd - b_rx, 1);
        check("frm_next_data", o_rx_data, 8'h7E);
        check("frm_next_err", n_err - b_err, 1);
        pulse_rd();

        // 5. full TX FIFO and RX overrun
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_byte(8'h10 + 8'(i));
            if (i == 14) check("full_at15", o_tx_full, 1'b0);
            if (i == 15) check("full_at16", o_tx_full, 1'b1);
        end
        check("full_after17", o_tx_full, 1'b1);
        b_rx = n_rxd; b_tx = n_txd; b_err = n_err;
        loop = 1'b1;
        pulse_start();
        lim = 0;
        while (n_txd - b_tx < 16 && lim < 16 * FB * BIT + 1000) begin cyc(1); lim++; end
        cyc(400);
        check("ovr_tx_count", n_txd - b_tx, 16);
        check("ovr_rx_count", n_rxd - b_rx, 16);
        check("ovr_head", o_rx_data, 8'h10);
        check("ovr_not_full", o_tx_full, 1'b0);
        check("ovr_no_err_yet", n_err - b_err, 0);
        loop = 1'b0;
        send_frame(8'h99, 1'b0, BIT, 1'b1);
        check("ovr_err", n_err - b_err, 1);
        check("ovr_rx_still16", n_rxd - b_rx, 16);
        check("ovr_head_kept", o_rx_data, 8'h10);

        // 6. reset in the middle of TX data bit 3
        do_reset();
        wr_byte(8'hC3);
        wr_byte(8'h55);
        pulse_start();
        wait_tx_low("mid_start");
        cyc(80 + BIT * 4);
        check("mid_bit3", o_tx, 1'b0);
        b_tx = n_txd;
        i_rst = 1'b1; cyc(1);
        check("mid_rst_tx", o_tx, 1'b1);
        i_rst = 1'b0;
        check("mid_rx_empty", o_rx_empty, 1'b1);
        check("mid_tx_full", o_tx_full, 1'b0);
        pulse_start();
        cyc(2000);
        check("mid_tx_idle", o_tx, 1'b1);
        check("mid_no_done", n_txd - b_tx, 0);
        do_reset();

`ifdef UART_PARITY_EN
        b_rx = n_rxd; b_err = n_err;
        send_frame(8'h07, 1'b1, BIT, 1'b1);
        check("par_err", n_err - b_err, 1);
        check("par_no_done", n_rxd - b_rx, 0);
        check("par_empty", o_rx_empty, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
